wb_mem_slave: RTL and testbench
===============================

Name: wb_mem_slave

Overview:
Wishbone B4 pipelined-mode slave memory model. It is the responder to the L1 wishbone master port, used in the l1_cache bench and in SoC simulation as backing store. It accepts one request per cycle, commits writes and samples reads at accept time, and returns in-order acks or errors after a configurable latency. Stall is driven by outstanding-request limit and an optional pseudo-random stall injector.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; SEL_W = DATA_W/8
MEM_WORDS, 1024, memory depth in DATA_W words (power of 2)
BASE_ADDR, 32'h0, byte address of word 0
MAX_OUT, 8, max outstanding un-acked requests (power of 2, 2..16)
LFSR_SEED, 16'hACE1, stall-injector seed (nonzero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wb_cyc_i  in  1  bus cycle active
wb_stb_i  in  1  request strobe
wb_we_i  in  1  1=write, 0=read
wb_adr_i  in  ADDR_W  byte address
wb_dat_i  in  DATA_W  write data
wb_sel_i  in  SEL_W  byte enables
wb_stall_o  out  1  request not accepted this cycle
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination (address out of range)
wb_rty_o  out  1  retry; tied 0
wb_dat_o  out  DATA_W  read data, valid with ack on reads
cfg_latency  in  4  response latency in cycles (0 treated as 1)
cfg_stall_en  in  1  enable random stall injection

Behaviour:
- Reset (rst_n low, async): stall_o=0, ack_o=0, err_o=0, dat_o=0, FIFO empty, cycle counter=0, LFSR=LFSR_SEED. Memory contents are not reset.
- Accept: a request is accepted at a posedge where cyc_i & stb_i & !stall_o.
- stall_o = (count == MAX_OUT) | (cfg_stall_en & lfsr[1:0]==2'b00). Registered-free (combinational from state). Value is irrelevant while cyc_i=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle.
- Address check: in range iff BASE_ADDR <= adr < BASE_ADDR + MEM_WORDS*SEL_W. Word index = (adr-BASE_ADDR)>>log2(SEL_W). Low address bits are ignored.
- On accept, in range, write: for each sel bit set, update the byte in the memory in that cycle. sel=0 is a legal no-op write and is still acked.
- On accept, in range, read: sample the memory word that cycle. A read accepted the cycle after a write to the same word returns the new data.
- On accept, out of range: no memory access; the entry is marked err.
- Each accepted request pushes {err, rdata, ts=cycle counter} into the response FIFO. The cycle counter is an 8-bit free-running counter; wrap is safe because the head waits at most 15+MAX_OUT cycles.
- Response: let L = max(cfg_latency,1). If the FIFO is non-empty and (counter - head.ts) >= L (mod 256), pop the head that cycle and assert ack_o or err_o (never both) for exactly one cycle. dat_o = head.rdata for reads, 0 otherwise.
- Latency: a request accepted at edge T gets its ack during the cycle after edge T+L-1. L=1 means the ack is high in the cycle after acceptance.
- Throughput: one ack per cycle. Responses are strictly in order.
- Simultaneous push and pop: allowed; count is unchanged. When count==MAX_OUT, stall is asserted even if a pop occurs that cycle (conservative).
- cyc_i deasserted with entries outstanding: flush the FIFO synchronously at that edge. Memory writes already committed remain. No ack/err is emitted for flushed entries or while cyc_i=0.
- cfg_latency changes mid-traffic: the new L applies to the head comparison immediately; order is preserved.

Decomposition:
- Package wb_mem_pkg: DATA_W/ADDR_W defaults, the resp_entry_t struct {err, rdata, ts[7:0]}, the LFSR tap constant, and ts_t.
- Sub-module wb_resp_fifo: synchronous FIFO of resp_entry_t, depth MAX_OUT, with push/pop/flush/count/full/empty and head output.
- Top level holds the memory array, address decode, LFSR, counter and ack logic.

Test Plan:
1. Reset mid-traffic, then write 0xDEADBEEF sel=4'hF to 0x10, then read 0x10, L=2 -> write ack 2 cycles after accept, read ack with dat_o=0xDEADBEEF.
2. Write 0x11223344 to 0x20, then write 0xAABBCCDD sel=4'b0101, then read back -> 0x11BB33DD.
3. Back-to-back 8 reads, L=3, MAX_OUT=8, cfg_stall_en=0 -> stall never asserted; 8 consecutive ack cycles starting 3 cycles after the first accept; data in order.
4. L=15, issue 10 reads without stalls -> stall_o high after the 8th accept, until the first pop; all 10 acked in order.
5. Read 0x1000 with MEM_WORDS=1024 -> err_o=1 and ack_o=0 for one cycle; the next in-range read is acked normally.
6. cfg_stall_en=1, random requests, then drop cyc with 3 outstanding -> no lost or duplicated acks before the drop; zero acks after it; a scoreboard matches all data.

Source files
------------

// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the Wishbone pipelined memory slave.
//   resp_entry_t : one queued response {err, rdata, ts}
//   ts_t         : 8-bit accept timestamp taken from the free-running counter
//   LFSR_TAPS    : Fibonacci taps 16,14,13,11 of the stall injector
// The response entry carries PKG_DATA_W bits of read data, so the slave's
// DATA_W parameter must be left equal to PKG_DATA_W.
package wb_mem_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;

  // Bit i set means tap at stage i+1: stages 16, 14, 13, 11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [7:0] ts_t;

  typedef struct packed {
    logic                  err;
    logic [PKG_DATA_W-1:0] rdata;
    ts_t                   ts;
  } resp_entry_t;

  // One Fibonacci step: shift left, feed back the XOR of the tapped stages.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wb_resp_fifo.sv
// In-order response queue for wb_mem_slave.
//   push_i/push_entry_i : enqueue one response (ignored when full)
//   pop_i               : dequeue the head (ignored when empty)
//   flush_i             : drop every entry at this edge
//   head_o              : oldest entry, valid while empty_o is low
//   count_o/full_o/empty_o : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_resp_fifo
  import wb_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  resp_entry_t            push_entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output resp_entry_t            head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  resp_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined slave memory model.
//   wb_cyc_i/wb_stb_i/wb_we_i/wb_adr_i/wb_dat_i/wb_sel_i : request
//   wb_stall_o : request not taken this cycle (outstanding limit or injector)
//   wb_ack_o/wb_err_o/wb_dat_o : in-order termination, one per cycle max
//   wb_rty_o   : never used, tied low
//   cfg_latency  : response latency in cycles (0 behaves as 1)
//   cfg_stall_en : enable pseudo-random stall injection
// Writes commit and reads sample at accept; the response is queued with an
// accept timestamp and released once it has aged by the configured latency.
module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int               ADDR_W    = PKG_ADDR_W,
  parameter int               DATA_W    = PKG_DATA_W,
  parameter int               MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               MAX_OUT   = 8,
  parameter logic [15:0]      LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  output logic                wb_stall_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [3:0]          cfg_latency,
  input  logic                cfg_stall_en
);

  localparam int SEL_W     = DATA_W / 8;
  localparam int OFF_W     = $clog2(SEL_W);
  localparam int IDX_W     = $clog2(MEM_WORDS);
  localparam int CNT_W     = $clog2(MAX_OUT) + 1;
  localparam int MEM_BYTES = MEM_WORDS * SEL_W;
  localparam logic [ADDR_W:0]  MEM_BYTES_W = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [CNT_W-1:0] MAX_OUT_C   = CNT_W'(MAX_OUT);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [15:0]       lfsr_q, lfsr_d;
  ts_t               cnt_q, cnt_d;

  logic [ADDR_W:0]   offset;
  logic              in_range;
  logic [IDX_W-1:0]  word_idx;
  logic              accept;

  resp_entry_t       push_entry, head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              resp_fire;
  logic [3:0]        lat_eff;
  ts_t               head_age;

  // Address decode: the extra MSB catches adr < BASE_ADDR as a borrow, which
  // makes the offset huge and therefore out of range in the single compare.
  assign offset   = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
  assign in_range = (offset < MEM_BYTES_W);
  assign word_idx = offset[OFF_W +: IDX_W];

  // Stall at the limit even if a pop frees a slot this cycle.
  assign wb_stall_o = (fifo_count == MAX_OUT_C) ||
                      (cfg_stall_en && (lfsr_q[1:0] == 2'b00));
  assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;

  // Byte-lane writes commit at the accepting edge; contents are not reset.
  always_ff @(posedge clk) begin
    if (accept && in_range && wb_we_i) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (wb_sel_i[b]) mem[word_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.err   = !in_range;
    push_entry.ts    = cnt_q;
    if (in_range && !wb_we_i) push_entry.rdata = mem[word_idx];

    lfsr_d = lfsr_next(lfsr_q);
    cnt_d  = cnt_q + 8'd1;

    // Age is taken mod 256; the head can never wait long enough to alias.
    lat_eff   = (cfg_latency == 4'd0) ? 4'd1 : cfg_latency;
    head_age  = cnt_q - head.ts;
    resp_fire = wb_cyc_i && !fifo_empty && (head_age >= {4'd0, lat_eff});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
    end
  end

  wb_resp_fifo #(
    .DEPTH (MAX_OUT)
  ) u_resp_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (accept && !fifo_full),
    .push_entry_i (push_entry),
    .pop_i        (resp_fire),
    .flush_i      (!wb_cyc_i),
    .head_o       (head),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign wb_ack_o = resp_fire && !head.err;
  assign wb_err_o = resp_fire && head.err;
  assign wb_dat_o = wb_ack_o ? head.rdata : '0;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave (default parameters: 1024 words, MAX_OUT=8).
module tb_wb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stall_o, wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  cfg_latency;
  logic        cfg_stall_en;

  wb_mem_slave dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_i     (wb_sel_i),
    .wb_stall_o   (wb_stall_o),
    .wb_ack_o     (wb_ack_o),
    .wb_err_o     (wb_err_o),
    .wb_rty_o     (wb_rty_o),
    .wb_dat_o     (wb_dat_o),
    .cfg_latency  (cfg_latency),
    .cfg_stall_en (cfg_stall_en)
  );

  always #5 clk = ~clk;

  // Edge counter: read #1 after a posedge it equals the number of that edge.
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          cyc;
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  rsp_t rsp_q[$];
  int   both_cnt = 0;

  // Record every termination mid-cycle, tagged with the preceding edge number.
  always @(negedge clk) begin
    if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
      rsp_q.push_back('{cyc: cyc_n, ack: wb_ack_o, err: wb_err_o, dat: wb_dat_o});
      if (wb_ack_o && wb_err_o) both_cnt++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int i, input logic ack,
                         input logic err, input logic [31:0] dat);
    check($sformatf("%s[%0d] ack", tag, i), 32'(rsp_q[i].ack), 32'(ack));
    check($sformatf("%s[%0d] err", tag, i), 32'(rsp_q[i].err), 32'(err));
    check($sformatf("%s[%0d] dat", tag, i), rsp_q[i].dat, dat);
  endtask

  // Caller must be at posedge+1. Returns the accepting edge number and the
  // number of cycles the request was stalled.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output int k, output int stalls);
    int w;
    w = 0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    @(negedge clk);
    while (wb_stall_o === 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("stall timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    k        = cyc_n;
    stalls   = w;
    wb_stb_i = 1'b0;
  endtask

  // Wait (bounded) for n recorded responses, linger to expose duplicates,
  // then realign to posedge+1.
  task automatic wait_rsp(input int n, input string tag);
    int w;
    w = 0;
    while (rsp_q.size() < n && w < 400) begin
      @(negedge clk);
      #1;
      w++;
    end
    repeat (4) @(negedge clk);
    #1;
    check({tag, " count"}, 32'(rsp_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, st, k0, k1, k2;
    int          ks[10], sts[10];
    int          tot_st;
    int          idx;
    logic        we;
    logic [31:0] d;
    logic [3:0]  sel;
    logic [31:0] model[8];
    logic [31:0] exp_q[$];

    rst_n        = 1'b0;
    wb_cyc_i     = 1'b0;
    wb_stb_i     = 1'b0;
    wb_we_i      = 1'b0;
    wb_adr_i     = '0;
    wb_dat_i     = '0;
    wb_sel_i     = '0;
    cfg_latency  = 4'd2;
    cfg_stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- 1: reset mid-traffic, then write/read with L=2 ----
    issue(1'b1, 32'h4, 32'h0000_1234, 4'hF, k, st);
    issue(1'b0, 32'h0, 32'h0, 4'hF, k, st);
    rst_n        = 1'b0;
    cfg_stall_en = 1'b1;
    #2;
    check("reset stall", 32'(wb_stall_o), 32'd0);
    check("reset ack",   32'(wb_ack_o),   32'd0);
    check("reset err",   32'(wb_err_o),   32'd0);
    check("reset dat",   wb_dat_o,        32'd0);
    check("rty tied",    32'(wb_rty_o),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    cfg_stall_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no ack from flushed-by-reset entries", 32'(rsp_q.size()), 32'd0);
    rsp_q.delete();

    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, k1, st);
    issue(1'b0, 32'h10, 32'h0, 4'hF, k2, st);
    wait_rsp(2, "t1");
    check("t1 back-to-back accept", 32'(k2), 32'(k1 + 1));
    chk_rsp("t1", 0, 1'b1, 1'b0, 32'h0);
    check("t1 write ack cycle", 32'(rsp_q[0].cyc), 32'(k1 + 1));
    chk_rsp("t1", 1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("t1 read ack cycle", 32'(rsp_q[1].cyc), 32'(k2 + 1));
    rsp_q.delete();

    // ---- 2: byte-lane merge and sel=0 no-op write ----
    issue(1'b1, 32'h20, 32'h1122_3344, 4'hF,    k, st);
    issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, k, st);
    issue(1'b0, 32'h20, 32'h0,         4'hF,    k, st);
    issue(1'b1, 32'h22, 32'hFFFF_FFFF, 4'h0,    k, st);
    issue(1'b0, 32'h23, 32'h0,         4'hF,    k, st);
    wait_rsp(5, "t2");
    chk_rsp("t2", 2, 1'b1, 1'b0, 32'h11BB_33DD);
    chk_rsp("t2", 3, 1'b1, 1'b0, 32'h0);
    chk_rsp("t2", 4, 1'b1, 1'b0, 32'h11BB_33DD);
    rsp_q.delete();

    // ---- 3: 8 back-to-back reads, L=3 ----
    cfg_latency = 4'd3;
    for (int i = 0; i < 8; i++)
      issue(1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, k, st);
    wait_rsp(8, "t3 preload");
    rsp_q.delete();
    for (int i = 0; i < 8; i++)
      issue(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF, ks[i], sts[i]);
    wait_rsp(8, "t3");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3[%0d] stalls", i), 32'(sts[i]), 32'd0);
      check($sformatf("t3[%0d] accept edge", i), 32'(ks[i]), 32'(ks[0] + i));
      check($sformatf("t3[%0d] ack cycle", i), 32'(rsp_q[i].cyc), 32'(ks[0] + 2 + i));
      chk_rsp("t3", i, 1'b1, 1'b0, 32'hC0DE_0000 + 32'(i));
    end
    rsp_q.delete();

    // ---- 4: L=15, 10 reads hit the outstanding limit ----
    cfg_latency = 4'd15;
    for (int i = 0; i < 10; i++)
      issue(1'b0, 32'h100 + 32'(4 * (i % 8)), 32'h0, 4'hF, ks[i], sts[i]);
    wait_rsp(10, "t4");
    k0 = ks[0];
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4[%0d] stalls", i), 32'(sts[i]), 32'd0);
      check($sformatf("t4[%0d] accept edge", i), 32'(ks[i]), 32'(k0 + i));
      check($sformatf("t4[%0d] ack cycle", i), 32'(rsp_q[i].cyc), 32'(k0 + 14 + i));
    end
    check("t4 9th stall cycles", 32'(sts[8]), 32'd8);
    check("t4 9th accept edge",  32'(ks[8]), 32'(k0 + 16));
    check("t4 10th accept edge", 32'(ks[9]), 32'(k0 + 17));
    check("t4 9th ack cycle",    32'(rsp_q[8].cyc), 32'(k0 + 30));
    check("t4 10th ack cycle",   32'(rsp_q[9].cyc), 32'(k0 + 31));
    for (int i = 0; i < 10; i++)
      chk_rsp("t4", i, 1'b1, 1'b0, 32'hC0DE_0000 + 32'(i % 8));
    rsp_q.delete();

    // ---- 5: range boundary, latency 0 behaves as 1 ----
    cfg_latency = 4'd0;
    issue(1'b1, 32'hFFC, 32'h5A5A_0FFC, 4'hF, k, st);
    issue(1'b1, 32'h0,   32'h0BAD_F00D, 4'hF, k, st);
    wait_rsp(2, "t5 preload");
    rsp_q.delete();
    issue(1'b0, 32'h1000, 32'h0,         4'hF, k0, st);
    issue(1'b0, 32'hFFC,  32'h0,         4'hF, k, st);
    issue(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, k, st);
    issue(1'b0, 32'h0,    32'h0,         4'hF, k, st);
    wait_rsp(4, "t5");
    chk_rsp("t5", 0, 1'b0, 1'b1, 32'h0);
    check("t5 err cycle", 32'(rsp_q[0].cyc), 32'(k0));
    chk_rsp("t5", 1, 1'b1, 1'b0, 32'h5A5A_0FFC);
    chk_rsp("t5", 2, 1'b0, 1'b1, 32'h0);
    chk_rsp("t5", 3, 1'b1, 1'b0, 32'h0BAD_F00D);
    rsp_q.delete();

    // ---- 6: random stalls with scoreboard, then drop cyc mid-flight ----
    cfg_latency  = 4'd4;
    cfg_stall_en = 1'b1;
    tot_st       = 0;
    for (int i = 0; i < 8; i++) begin
      model[i] = 32'h6000_0000 + 32'(i * 16'h1111);
      issue(1'b1, 32'h200 + 32'(4 * i), model[i], 4'hF, k, st);
      exp_q.push_back(32'h0);
      tot_st += st;
    end
    for (int i = 0; i < 20; i++) begin
      we  = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 7));
      d   = $urandom;
      sel = 4'($urandom_range(0, 15));
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(model[idx]);
      end
      issue(we, 32'h200 + 32'(4 * idx), d, sel, k, st);
      tot_st += st;
    end
    wait_rsp(28, "t6");
    check("t6 injector stalled", 32'(tot_st > 0), 32'd1);
    for (int i = 0; i < 28; i++)
      chk_rsp("t6", i, 1'b1, 1'b0, exp_q[i]);
    rsp_q.delete();

    cfg_latency = 4'd15;
    issue(1'b1, 32'h300, 32'hA1A1_A1A1, 4'hF, k, st);
    issue(1'b1, 32'h304, 32'hA2A2_A2A2, 4'hF, k, st);
    issue(1'b1, 32'h308, 32'hA3A3_A3A3, 4'hF, k, st);
    wb_cyc_i = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("t6 no acks after cyc drop", 32'(rsp_q.size()), 32'd0);
    cfg_stall_en = 1'b0;
    cfg_latency  = 4'd1;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h300, 32'h0, 4'hF, k, st);
    issue(1'b0, 32'h304, 32'h0, 4'hF, k, st);
    issue(1'b0, 32'h308, 32'h0, 4'hF, k, st);
    wait_rsp(3, "t6 readback");
    chk_rsp("t6 rb", 0, 1'b1, 1'b0, 32'hA1A1_A1A1);
    chk_rsp("t6 rb", 1, 1'b1, 1'b0, 32'hA2A2_A2A2);
    chk_rsp("t6 rb", 2, 1'b1, 1'b0, 32'hA3A3_A3A3);

    check("ack and err never together", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
